// File: rtl/entropy_sample_conditioner.sv
// Entropy sample conditioner: windowed average of raw 16-bit samples plus a hysteresis FSM
// that raises a one-shot flush request and a sustained stall request.
// Latency: average 1 clock after accept, FSM/flush/stall 2 clocks; s_ready is always high out of reset.
// Optional macro ENTROPY_COND_STALE_EN builds an idle-sample watchdog that drives `stale`.
module entropy_sample_conditioner #(
    parameter int          AVG_LOG2     = 2,
    parameter logic [15:0] HI_THRESH    = 16'd48000,
    parameter logic [15:0] LO_THRESH    = 16'd32000,
    parameter int          HOLD_CYCLES  = 8,
    parameter int          STALE_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    output logic [15:0] external_entropy_out,
    output logic [7:0]  entropy_score_out,
    output logic        flush_req,
    output logic        stall_req,
    output logic [1:0]  cond_state,
    output logic        stale
);

    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int SUM_W  = 16 + AVG_LOG2;
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        ALERT = 2'b10,
        COOL  = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         win_q [DEPTH];
    logic [15:0]         win_d [DEPTH];
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [15:0]         avg_q, avg_d;
    logic [7:0]          score_q, score_d;
    logic                s_ready_q, s_ready_d;
    logic                acc_q, acc_d;
    logic [HOLD_W-1:0]   cool_cnt_q, cool_cnt_d;
    logic                flush_q, flush_d;
    logic                stall_q, stall_d;
    logic                stale_q, stale_d;
    logic                accept;

    assign accept = s_valid && s_ready_q;

    // Window shift and running sum: newest sample enters at index 0, oldest drops out of the sum.
    always_comb begin
        win_d     = win_q;
        sum_d     = sum_q;
        avg_d     = avg_q;
        score_d   = score_q;
        s_ready_d = 1'b1;
        acc_d     = accept;
        if (accept) begin
            win_d[0] = s_data;
            for (int i = 1; i < DEPTH; i++) begin
                win_d[i] = win_q[i-1];
            end
            sum_d   = sum_q + SUM_W'(s_data) - SUM_W'(win_q[DEPTH-1]);
            avg_d   = 16'(sum_d >> AVG_LOG2);
            score_d = avg_d[15:8];
        end
    end

    // Hysteresis FSM on the registered average; flush marks each ALERT entry for one clock.
    always_comb begin
        state_d    = state_q;
        cool_cnt_d = cool_cnt_q;
        flush_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc_q) state_d = TRACK;
            end
            TRACK: begin
                if (avg_q >= HI_THRESH) begin
                    state_d = ALERT;
                    flush_d = 1'b1;
                end
            end
            ALERT: begin
                if (avg_q < LO_THRESH) begin
                    state_d    = COOL;
                    cool_cnt_d = HOLD_W'(HOLD_CYCLES);
                end
            end
            COOL: begin
                cool_cnt_d = (cool_cnt_q == '0) ? '0 : cool_cnt_q - 1'b1;
                // A fresh excursion wins over cooldown expiry on the same clock.
                if (avg_q >= HI_THRESH) begin
                    state_d = ALERT;
                    flush_d = 1'b1;
                end else if (cool_cnt_q <= HOLD_W'(1)) begin
                    state_d = TRACK;
                end
            end
            default: state_d = IDLE;
        endcase
        stall_d = (state_d == ALERT) || (state_d == COOL) || stale_d;
    end

`ifdef ENTROPY_COND_STALE_EN
    localparam int STALE_W = $clog2(STALE_CYCLES + 1);

    logic [STALE_W-1:0] stale_cnt_q, stale_cnt_d;

    // Idle watchdog: counts clocks without an accept once active, saturating at the limit.
    always_comb begin
        stale_cnt_d = stale_cnt_q;
        if (accept) begin
            stale_cnt_d = '0;
        end else if ((state_q != IDLE) && (stale_cnt_q != STALE_W'(STALE_CYCLES))) begin
            stale_cnt_d = stale_cnt_q + 1'b1;
        end
        stale_d = !accept && (stale_cnt_d == STALE_W'(STALE_CYCLES));
    end

    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (rst) stale_cnt_q <= '0;
        else     stale_cnt_q <= stale_cnt_d;
    end
`else
    // No watchdog in this build; the idle limit still shares the parameter list.
    assign stale_d = 1'b0 && (STALE_CYCLES > 0);
`endif

    // All state and outputs registered; reset wins over any accept or pending transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                win_q[i] <= '0;
            end
            sum_q      <= '0;
            avg_q      <= '0;
            score_q    <= '0;
            s_ready_q  <= 1'b0;
            acc_q      <= 1'b0;
            state_q    <= IDLE;
            cool_cnt_q <= '0;
            flush_q    <= 1'b0;
            stall_q    <= 1'b0;
            stale_q    <= 1'b0;
        end else begin
            win_q      <= win_d;
            sum_q      <= sum_d;
            avg_q      <= avg_d;
            score_q    <= score_d;
            s_ready_q  <= s_ready_d;
            acc_q      <= acc_d;
            state_q    <= state_d;
            cool_cnt_q <= cool_cnt_d;
            flush_q    <= flush_d;
            stall_q    <= stall_d;
            stale_q    <= stale_d;
        end
    end

    assign s_ready              = s_ready_q;
    assign external_entropy_out = avg_q;
    assign entropy_score_out    = score_q;
    assign flush_req            = flush_q;
    assign stall_req            = stall_q;
    assign cond_state           = state_q;
    assign stale                = stale_q;

endmodule
